usb_tx_arbiter: RTL
===================

// Module: usb_tx_arbiter
// PURPOSE
//  Sequences the single USB transmit driver between response generators (ACK, device/config/
//  interface/endpoint descriptor). Latches one-cycle answer requests from the PID analyser,
//  grants one generator at a time with a fixed priority and enforces bus turnaround and
//  recovery gaps. Owns the shared output-enable. Packet-timeout watchdog on the holder.
// PARAMETERS
//  NUM_REQ      5     number of requesters; index 0 = highest priority (ACK)
//  GAP_BITS     2     bit times (checkData strobes) between bus idle and grant
//  RECOVER_BITS 2     bit times after release before next arbitration
//  MAX_PKT_BITS 1023  bit-time watchdog for a held grant; counter width = $clog2(MAX_PKT_BITS+1)
// PORTS
//  useClk         in   1        system clock
//  resetN         in   1        asynchronous active-low reset
//  checkData      in   1        bit-time strobe; all bit counters advance only when high
//  busRxActive    in   1        host packet in progress on the line (high until EOP seen)
//  req            in   NUM_REQ  one-useClk request pulses (answerACK, answerDesc, ...)
//  done           in   NUM_REQ  one-useClk end-of-packet pulses from generators (callEop*)
//  grant          out  NUM_REQ  one-hot; high while that generator may drive
//  txOe           out  1        OR of grant, registered; drives the shared transceiver OE
//  selIdx         out  3        index of current/last grant holder
//  pending        out  NUM_REQ  latched, not-yet-served requests
//  timeoutErr     out  1        one-useClk pulse when watchdog releases a grant
// BEHAVIOUR
//  Reset (resetN low, async): state IDLE; grant, txOe, selIdx, pending, timeoutErr, counters = 0.
//  Reset mid-packet drops grant/txOe immediately; all pending requests lost.
//  Pending: pending[i] set on req[i]; cleared on the cycle grant[i] is asserted. req[i] on that
//   same cycle: set wins (pending[i] stays 1, served again later). Repeated req while pending = 1.
//  FSM (registered, transitions on useClk):
//   IDLE    : if |pending && !busRxActive -> GAP, clear bit counter.
//   GAP     : count checkData strobes; busRxActive high -> IDLE (pending kept).
//             count == GAP_BITS -> ACTIVE; selIdx = lowest set pending index (captured at the
//             transition, not on GAP entry); grant[selIdx] = 1 same edge; counter cleared.
//   ACTIVE  : count strobes. done[selIdx] -> RECOVER, grant = 0 next edge. done[j], j != selIdx,
//             ignored. count == MAX_PKT_BITS without done -> RECOVER, grant = 0, timeoutErr = 1
//             for one useClk. done and timeout same cycle: done wins, no timeoutErr.
//             busRxActive is ignored in ACTIVE (our driver owns the line).
//   RECOVER : count strobes; count == RECOVER_BITS -> IDLE.
//  Latency: req pulse in IDLE with bus idle and checkData every cycle -> grant asserted
//   GAP_BITS+1 useClk later. txOe equals |grant of the same cycle (registered together).
//  Counters saturate-free: cleared on every state entry; width sized for MAX_PKT_BITS.
//  selIdx holds value after release until next grant. Only one grant bit ever high.
//  checkData low freezes counters but not state-exit on done/busRxActive.
// STRUCTURE
//  Package usb_pkg: state localparams (ST_IDLE, ST_GAP, ST_ACTIVE, ST_RECOVER), requester
//   indices REQ_ACK=0, REQ_DESC=1, REQ_CONFIG=2, REQ_INTERFACE=3, REQ_ENDPOINT=4.
//  Sub-module usb_prio_pick: combinational fixed-priority encoder, pending -> {valid, index}.
//  Top: pending latches, FSM, one bit counter shared by GAP/ACTIVE/RECOVER, output registers.
// TESTING
//  1 Reset: resetN low during ACTIVE -> grant=0, txOe=0, pending=0 asynchronously; IDLE after.
//  2 Single: req=5'b00001, bus idle, checkData always 1 -> grant=5'b00001 3 clocks later;
//    done[0] -> grant=0 next clock; IDLE after 2 recover strobes.
//  3 Priority: req=5'b10010 same cycle -> grant[1] first, pending=5'b10000; after done[1]
//    and recovery grant[4], selIdx=4.
//  4 Gap abort: req[0], busRxActive rises during GAP -> back to IDLE, no grant, pending[0]=1;
//    busRxActive low -> grant[0] after GAP_BITS strobes.
//  5 Timeout: MAX_PKT_BITS=15, grant[1], no done -> grant drops after 15 strobes,
//    timeoutErr one-clock pulse; done[3] during ACTIVE ignored.
//  6 Set-wins: req[2] on the grant[2] cycle -> pending[2] stays 1, served a second time.

Source files
------------

// File: rtl/usb_pkg.sv
// ============================================================================
// Module : usb_pkg
// Brief  : Shared state encoding and requester indices for the USB TX arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package usb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GAP     = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RECOVER = 2'd3
  } txState_t;

  localparam int IDX_W         = 3;
  localparam int REQ_ACK       = 0;
  localparam int REQ_DESC      = 1;
  localparam int REQ_CONFIG    = 2;
  localparam int REQ_INTERFACE = 3;
  localparam int REQ_ENDPOINT  = 4;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/usb_prio_pick.sv
// ============================================================================
// Module : usb_prio_pick
// Brief  : Fixed-priority encoder; lowest set pending bit wins.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module usb_prio_pick
  import usb_pkg::*;
#(
  parameter int NUM_REQ = 5
) (
  input  logic [NUM_REQ-1:0] pending,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  always_comb begin
    valid = |pending;
    index = '0;
    // Walk downward so the lowest index is the last (winning) assignment.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pending[i]) index = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/usb_tx_arbiter.sv
// ============================================================================
// Module : usb_tx_arbiter
// Brief  : Grants the shared USB transmit driver to one response generator at a
//          time, with turnaround/recovery gaps and a packet-length watchdog.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module usb_tx_arbiter
  import usb_pkg::*;
#(
  parameter int NUM_REQ      = 5,
  parameter int GAP_BITS     = 2,
  parameter int RECOVER_BITS = 2,
  parameter int MAX_PKT_BITS = 1023
) (
  input  logic               useClk,
  input  logic               resetN,
  input  logic               checkData,
  input  logic               busRxActive,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               txOe,
  output logic [IDX_W-1:0]   selIdx,
  output logic [NUM_REQ-1:0] pending,
  output logic               timeoutErr
);

  localparam int CNT_W = $clog2(maxOf3(MAX_PKT_BITS, GAP_BITS, RECOVER_BITS) + 1);

  txState_t             r_state,   w_stateNext;
  logic [CNT_W-1:0]     r_cnt,     w_cntNext;
  logic [NUM_REQ-1:0]   r_grant,   w_grantNext;
  logic [NUM_REQ-1:0]   r_pending;
  logic [IDX_W-1:0]     r_selIdx,  w_selNext;
  logic                 r_txOe;
  logic                 r_timeout, w_timeoutNext;
  logic [NUM_REQ-1:0]   w_clrMask;
  logic [CNT_W-1:0]     w_cntStep;
  logic                 w_pickValid;
  logic [IDX_W-1:0]     w_pickIdx;
  logic [NUM_REQ-1:0]   w_pickOh;

  usb_prio_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .pending (r_pending),
    .valid   (w_pickValid),
    .index   (w_pickIdx)
  );

  // Count including this cycle's strobe, so an exit fires on the Nth strobe itself.
  assign w_cntStep = r_cnt + CNT_W'(checkData);
  assign w_pickOh  = NUM_REQ'(1) << w_pickIdx;

  always_ff @(posedge useClk or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext   = r_state;
    w_cntNext     = w_cntStep;
    w_grantNext   = r_grant;
    w_selNext     = r_selIdx;
    w_timeoutNext = 1'b0;
    w_clrMask     = '0;
    case (r_state)
      ST_IDLE: begin
        w_cntNext = '0;
        if (|r_pending && !busRxActive) w_stateNext = ST_GAP;
      end
      ST_GAP: begin
        if (busRxActive || !w_pickValid) begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end else if (w_cntStep >= CNT_W'(GAP_BITS)) begin
          w_stateNext = ST_ACTIVE;
          w_cntNext   = '0;
          w_selNext   = w_pickIdx;
          w_grantNext = w_pickOh;
          w_clrMask   = w_pickOh;
        end
      end
      ST_ACTIVE: begin
        // The grant is one-hot at selIdx, so masking done with it selects done[selIdx].
        if (|(done & r_grant)) begin
          w_stateNext = ST_RECOVER;
          w_cntNext   = '0;
          w_grantNext = '0;
        end else if (w_cntStep >= CNT_W'(MAX_PKT_BITS)) begin
          w_stateNext   = ST_RECOVER;
          w_cntNext     = '0;
          w_grantNext   = '0;
          w_timeoutNext = 1'b1;
        end
      end
      ST_RECOVER: begin
        if (w_cntStep >= CNT_W'(RECOVER_BITS)) begin
          w_stateNext = ST_IDLE;
          w_cntNext   = '0;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
        w_cntNext   = '0;
        w_grantNext = '0;
      end
    endcase
  end

  always_ff @(posedge useClk or negedge resetN) begin
    if (!resetN) begin
      r_cnt     <= '0;
      r_grant   <= '0;
      r_txOe    <= 1'b0;
      r_selIdx  <= '0;
      r_pending <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cntNext;
      r_grant   <= w_grantNext;
      r_txOe    <= |w_grantNext;
      r_selIdx  <= w_selNext;
      r_pending <= (r_pending & ~w_clrMask) | req;
      r_timeout <= w_timeoutNext;
    end
  end

  assign grant      = r_grant;
  assign txOe       = r_txOe;
  assign selIdx     = r_selIdx;
  assign pending    = r_pending;
  assign timeoutErr = r_timeout;

endmodule

`default_nettype wire
